scr1_tapc_ovs: RTL and testbench

Single-clock JTAG TAP controller for the debug subsystem. It oversamples the external TCK/TMS/TDI pins in the core clock domain and runs the IEEE 1149.1 16-state TAP FSM. It holds the instruction register, IDCODE and BYPASS registers, and drives the DTMCS/DMI chain strobes (select, id, capture, shift, update, tdi) into the DMI block. It returns that block's TDO to the pin.

---
 rtl/scr1_tapc_ovs.sv | 190 +++++++++++++++++++
 tb/tb_scr1_tapc_ovs.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tapc_ovs.sv
// JTAG TAP controller that oversamples TCK/TMS/TDI/TRST_n in the core clock domain and
// drives IR, IDCODE, BYPASS and the DTMCS/DMI chain strobes.
module scr1_tapc_ovs #(
    parameter int unsigned IR_WIDTH    = 5,
    parameter logic [31:0] IDCODE_VAL  = 32'hDEB11001,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tapc_trst_n_i,
    input  logic       tapc_tck_i,
    input  logic       tapc_tms_i,
    input  logic       tapc_tdi_i,
    output logic       tapc_tdo_o,
    output logic       tapc_tdo_en_o,
    output logic       tapc2dmi_ch_sel_o,
    output logic [1:0] tapc2dmi_ch_id_o,
    output logic       tapc2dmi_ch_capture_o,
    output logic       tapc2dmi_ch_shift_o,
    output logic       tapc2dmi_ch_update_o,
    output logic       tapc2dmi_ch_tdi_o,
    input  logic       dmi2tapc_ch_tdo_i
);

    localparam logic [IR_WIDTH-1:0] IrIdcode = IR_WIDTH'('h01);
    localparam logic [IR_WIDTH-1:0] IrDtmcs  = IR_WIDTH'('h10);
    localparam logic [IR_WIDTH-1:0] IrDmi    = IR_WIDTH'('h11);

    typedef enum logic [3:0] {
        StTlr, StRti, StSelDr, StCapDr, StShDr, StEx1Dr, StPauDr, StEx2Dr, StUpdDr,
        StSelIr, StCapIr, StShIr, StEx1Ir, StPauIr, StEx2Ir, StUpdIr
    } tap_state_e;

    logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trst_sync_q;
    logic                   tck_prev_q;
    logic                   tck_s, tms_s, tdi_s, trst_act;
    logic                   tck_rise, tck_fall;

    tap_state_e             state_q, state_d;
    logic [IR_WIDTH-1:0]    ir_q, ir_shift_q;
    logic [31:0]            idcode_q;
    logic                   bypass_q;
    logic                   tdo_q, tdo_en_q;
    logic                   ch_sel_q, capture_q, shift_q, update_q, ch_tdi_q;
    logic [1:0]             ch_id_q;

    logic                   ir_is_chain;
    logic [1:0]             ir_ch_id;
    logic                   dr_lsb;

    // TRST_n chain resets to "asserted" so the TAP stays held until the pin is seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
            trst_sync_q <= '0;
            tck_prev_q  <= 1'b0;
        end else begin
            tck_sync_q  <= {tck_sync_q[SYNC_STAGES-2:0], tapc_tck_i};
            tms_sync_q  <= {tms_sync_q[SYNC_STAGES-2:0], tapc_tms_i};
            tdi_sync_q  <= {tdi_sync_q[SYNC_STAGES-2:0], tapc_tdi_i};
            trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], tapc_trst_n_i};
            tck_prev_q  <= tck_s;
        end
    end

    assign tck_s    = tck_sync_q[SYNC_STAGES-1];
    assign tms_s    = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
    assign trst_act = ~trst_sync_q[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StTlr:   state_d = tms_s ? StTlr   : StRti;
            StRti:   state_d = tms_s ? StSelDr : StRti;
            StSelDr: state_d = tms_s ? StSelIr : StCapDr;
            StCapDr: state_d = tms_s ? StEx1Dr : StShDr;
            StShDr:  state_d = tms_s ? StEx1Dr : StShDr;
            StEx1Dr: state_d = tms_s ? StUpdDr : StPauDr;
            StPauDr: state_d = tms_s ? StEx2Dr : StPauDr;
            StEx2Dr: state_d = tms_s ? StUpdDr : StShDr;
            StUpdDr: state_d = tms_s ? StSelDr : StRti;
            StSelIr: state_d = tms_s ? StTlr   : StCapIr;
            StCapIr: state_d = tms_s ? StEx1Ir : StShIr;
            StShIr:  state_d = tms_s ? StEx1Ir : StShIr;
            StEx1Ir: state_d = tms_s ? StUpdIr : StPauIr;
            StPauIr: state_d = tms_s ? StEx2Ir : StPauIr;
            StEx2Ir: state_d = tms_s ? StUpdIr : StShIr;
            StUpdIr: state_d = tms_s ? StSelDr : StRti;
            default: state_d = StTlr;
        endcase
    end

    always_comb begin
        ir_is_chain = (ir_q == IrDtmcs) || (ir_q == IrDmi);
        ir_ch_id    = (ir_q == IrDtmcs) ? 2'd1 : (ir_q == IrDmi) ? 2'd2 : 2'd0;
        // Unknown instructions fall through to BYPASS.
        if (ir_q == IrIdcode) begin
            dr_lsb = idcode_q[0];
        end else if (ir_is_chain) begin
            dr_lsb = dmi2tapc_ch_tdo_i;
        end else begin
            dr_lsb = bypass_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StTlr;
            ir_q       <= IrIdcode;
            ir_shift_q <= '0;
            idcode_q   <= '0;
            bypass_q   <= 1'b0;
            tdo_q      <= 1'b0;
            tdo_en_q   <= 1'b0;
            ch_sel_q   <= 1'b0;
            ch_id_q    <= 2'd0;
            capture_q  <= 1'b0;
            shift_q    <= 1'b0;
            update_q   <= 1'b0;
            ch_tdi_q   <= 1'b0;
        end else begin
            capture_q <= 1'b0;
            shift_q   <= 1'b0;
            update_q  <= 1'b0;
            ch_tdi_q  <= tdi_s;
            if (trst_act) begin
                state_q  <= StTlr;
                ir_q     <= IrIdcode;
                ch_sel_q <= 1'b0;
                ch_id_q  <= 2'd0;
                tdo_en_q <= 1'b0;
            end else begin
                ch_sel_q <= ir_is_chain;
                ch_id_q  <= ir_ch_id;
                if (tck_rise) begin
                    state_q <= state_d;
                    case (state_q)
                        StCapDr: begin
                            idcode_q  <= IDCODE_VAL;
                            bypass_q  <= 1'b0;
                            capture_q <= ch_sel_q;
                        end
                        StShDr: begin
                            idcode_q <= {tdi_s, idcode_q[31:1]};
                            bypass_q <= tdi_s;
                            shift_q  <= ch_sel_q;
                        end
                        StCapIr: ir_shift_q <= IR_WIDTH'('h01);
                        StShIr:  ir_shift_q <= {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
                        default: ;
                    endcase
                end
                if (tck_fall) begin
                    tdo_en_q <= 1'b0;
                    case (state_q)
                        StShDr: begin
                            tdo_q    <= dr_lsb;
                            tdo_en_q <= 1'b1;
                        end
                        StShIr: begin
                            tdo_q    <= ir_shift_q[0];
                            tdo_en_q <= 1'b1;
                        end
                        StUpdDr: update_q <= ch_sel_q;
                        StUpdIr: ir_q     <= ir_shift_q;
                        default: ;
                    endcase
                end
                if (state_q == StTlr) begin
                    ir_q <= IrIdcode;
                end
            end
        end
    end

    assign tapc_tdo_o            = tdo_q;
    assign tapc_tdo_en_o         = tdo_en_q;
    assign tapc2dmi_ch_sel_o     = ch_sel_q;
    assign tapc2dmi_ch_id_o      = ch_id_q;
    assign tapc2dmi_ch_capture_o = capture_q;
    assign tapc2dmi_ch_shift_o   = shift_q;
    assign tapc2dmi_ch_update_o  = update_q;
    assign tapc2dmi_ch_tdi_o     = ch_tdi_q;

endmodule

// File: tb/tb_scr1_tapc_ovs.sv
// Directed bench for scr1_tapc_ovs: TCK is driven at 1/8 of clk and a small DMI
// shift-register model sits on the chain interface.
module tb_scr1_tapc_ovs;

    localparam logic [31:0] IdcodeVal = 32'hDEB11001;
    localparam logic [40:0] DmiCap    = 41'h1_5A3C_96E1_7B;
    localparam logic [40:0] DmiIn     = 41'h0_C3A5_5AF0_19;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trst_n = 1'b1;
    logic       tck = 1'b0;
    logic       tms = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo, tdo_en, ch_sel, ch_cap, ch_sh, ch_upd, ch_tdi, dmi_tdo;
    logic [1:0] ch_id;

    logic [40:0] dmi_q = '0;
    int          cap_cnt = 0;
    int          sh_cnt = 0;
    int          upd_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    scr1_tapc_ovs dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .tapc_trst_n_i         (trst_n),
        .tapc_tck_i            (tck),
        .tapc_tms_i            (tms),
        .tapc_tdi_i            (tdi),
        .tapc_tdo_o            (tdo),
        .tapc_tdo_en_o         (tdo_en),
        .tapc2dmi_ch_sel_o     (ch_sel),
        .tapc2dmi_ch_id_o      (ch_id),
        .tapc2dmi_ch_capture_o (ch_cap),
        .tapc2dmi_ch_shift_o   (ch_sh),
        .tapc2dmi_ch_update_o  (ch_upd),
        .tapc2dmi_ch_tdi_o     (ch_tdi),
        .dmi2tapc_ch_tdo_i     (dmi_tdo)
    );

    // DMI-side chain model: loads DmiCap on capture, shifts ch_tdi in at the MSB.
    always @(posedge clk) begin
        if (ch_cap) dmi_q <= DmiCap;
        else if (ch_sh) dmi_q <= {ch_tdi, dmi_q[40:1]};
    end
    assign dmi_tdo = dmi_q[0];

    always @(negedge clk) begin
        if (ch_cap) cap_cnt++;
        if (ch_sh) sh_cnt++;
        if (ch_upd) upd_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One TCK period; TDO/TDO_en are sampled just before the rising edge.
    task automatic pulse(input logic tms_v, input logic tdi_v, output logic tdo_v,
                         output logic en_v);
        tms = tms_v;
        tdi = tdi_v;
        repeat (4) @(negedge clk);
        tdo_v = tdo;
        en_v  = tdo_en;
        tck   = 1'b1;
        repeat (4) @(negedge clk);
        tck = 1'b0;
    endtask

    task automatic step(input logic tms_v);
        logic t, e;
        pulse(tms_v, 1'b0, t, e);
    endtask

    // RTI -> SH_DR, n shifts, -> UPD_DR -> RTI.
    task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                           output int en_cnt);
        logic t, e;
        dout   = '0;
        en_cnt = 0;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < n; i++) begin
            pulse(i == n - 1, din[i], t, e);
            dout[i] = t;
            en_cnt += int'(e);
        end
        step(1'b1);
        step(1'b0);
    endtask

    // RTI -> SH_IR, 5 shifts, -> UPD_IR -> RTI.
    task automatic scan_ir(input logic [4:0] v, output logic [4:0] dout);
        logic t, e;
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 5; i++) begin
            pulse(i == 4, v[i], t, e);
            dout[i] = t;
        end
        step(1'b1);
        step(1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tdo"}, 64'(tdo), 64'd0);
        check({tag, "_tdo_en"}, 64'(tdo_en), 64'd0);
        check({tag, "_sel"}, 64'(ch_sel), 64'd0);
        check({tag, "_id"}, 64'(ch_id), 64'd0);
        check({tag, "_cap"}, 64'(ch_cap), 64'd0);
        check({tag, "_shift"}, 64'(ch_sh), 64'd0);
        check({tag, "_upd"}, 64'(ch_upd), 64'd0);
    endtask

    initial begin
        logic [63:0] dout;
        logic [4:0]  irout;
        int          en_cnt;
        int          c0, s0, u0;
        logic        t, e;

        // Reset
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        check("rst_tdi", 64'(ch_tdi), 64'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_all_zero("post_rst");

        // 1: IDCODE read
        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        for (int i = 0; i < 5; i++) step(1'b1);
        step(1'b0);
        scan_dr(32, 64'h0, dout, en_cnt);
        check("idcode_tdo", dout[31:0], 64'(IdcodeVal));
        check("idcode_tdo_en", 64'(en_cnt), 64'd32);
        check("idcode_sel", 64'(ch_sel), 64'd0);
        check("idcode_strobes", 64'((cap_cnt - c0) + (sh_cnt - s0) + (upd_cnt - u0)), 64'd0);
        check("idcode_en_after", 64'(tdo_en), 64'd0);

        // 2: DMI select and 41-bit scan
        scan_ir(5'h11, irout);
        check("ir_capture_out", 64'(irout), 64'h01);
        check("dmi_sel", 64'(ch_sel), 64'd1);
        check("dmi_id", 64'(ch_id), 64'd2);
        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        scan_dr(41, 64'(DmiIn), dout, en_cnt);
        check("dmi_tdo", dout[40:0], 64'(DmiCap));
        check("dmi_tdo_en", 64'(en_cnt), 64'd41);
        check("dmi_cap_cnt", 64'(cap_cnt - c0), 64'd1);
        check("dmi_shift_cnt", 64'(sh_cnt - s0), 64'd41);
        check("dmi_upd_cnt", 64'(upd_cnt - u0), 64'd1);
        check("dmi_tdi_path", 64'(dmi_q), 64'(DmiIn));

        // 3: DTMCS select
        scan_ir(5'h10, irout);
        check("dtmcs_id", 64'(ch_id), 64'd1);
        check("dtmcs_sel", 64'(ch_sel), 64'd1);
        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        scan_dr(32, 64'h0000_0000_1234_5678, dout, en_cnt);
        check("dtmcs_shift_cnt", 64'(sh_cnt - s0), 64'd32);
        check("dtmcs_cap_cnt", 64'(cap_cnt - c0), 64'd1);
        check("dtmcs_upd_cnt", 64'(upd_cnt - u0), 64'd1);

        // 4: BYPASS, explicit and via unknown opcode
        scan_ir(5'h1F, irout);
        check("byp1f_sel", 64'(ch_sel), 64'd0);
        check("byp1f_id", 64'(ch_id), 64'd0);
        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        scan_dr(4, 64'b1101, dout, en_cnt);
        check("byp1f_tdo", dout[3:0], 64'b1010);
        check("byp1f_strobes", 64'((cap_cnt - c0) + (sh_cnt - s0) + (upd_cnt - u0)), 64'd0);
        scan_ir(5'h05, irout);
        check("byp05_sel", 64'(ch_sel), 64'd0);
        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        scan_dr(4, 64'b1101, dout, en_cnt);
        check("byp05_tdo", dout[3:0], 64'b1010);
        check("byp05_strobes", 64'((cap_cnt - c0) + (sh_cnt - s0) + (upd_cnt - u0)), 64'd0);

        // 5: TRST_n mid-scan under DMI
        scan_ir(5'h11, irout);
        check("trst_pre_sel", 64'(ch_sel), 64'd1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        pulse(1'b0, 1'b1, t, e);
        pulse(1'b0, 1'b0, t, e);
        u0 = upd_cnt; s0 = sh_cnt;
        trst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("trst_sel", 64'(ch_sel), 64'd0);
        check("trst_tdo_en", 64'(tdo_en), 64'd0);
        check("trst_ir", 64'(dut.ir_q), 64'h01);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        check("trst_no_upd", 64'(upd_cnt - u0), 64'd0);
        check("trst_no_shift", 64'(sh_cnt - s0), 64'd0);
        trst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("trst_rel_id", 64'(ch_id), 64'd0);
        step(1'b0);
        scan_dr(32, 64'h0, dout, en_cnt);
        check("trst_idcode", dout[31:0], 64'(IdcodeVal));

        // 6: core reset mid SH_IR
        scan_ir(5'h11, irout);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        pulse(1'b0, 1'b1, t, e);
        repeat (4) @(negedge clk);
        check("shir_tdo_en", 64'(tdo_en), 64'd1);
        check("shir_sel", 64'(ch_sel), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        check("async_rst_tdi", 64'(ch_tdi), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) step(1'b1);
        step(1'b0);
        scan_dr(32, 64'h0, dout, en_cnt);
        check("rst_idcode", dout[31:0], 64'(IdcodeVal));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
